// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO over inferred RAM with FWFT or standard read mode, programmable flags and occupancy count.
// Optional macro SYNC_FIFO_ERR_FLAGS_EN adds the overflow/underflow pulse outputs.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH        = 16,
  parameter int FIFO_DEPTH        = 16,
  parameter int READ_MODE         = 1,
  parameter int PROG_FULL_THRESH  = 10,
  parameter int PROG_EMPTY_THRESH = 2,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  prog_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  prog_empty,
  output logic                  data_valid,
  output logic [CW-1:0]         data_count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int AW = CW - 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [CW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          progFull_q, progFull_d;
  logic          progEmpty_q, progEmpty_d;
  logic          wrAccept;
  logic          rdAccept;

  // Requests are qualified against the registered flags, so a write while full is dropped even if a read frees a slot that cycle.
  assign wrAccept = wr_en && !full_q;
  assign rdAccept = rd_en && !empty_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (wrAccept) begin
      wrPtr_d = wrPtr_q + CW'(1);
    end
    if (rdAccept) begin
      rdPtr_d = rdPtr_q + CW'(1);
    end
    case ({wrAccept, rdAccept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags derive from next-state pointers so they land in the same cycle as the pointer move.
  always_comb begin
    full_d      = (wrPtr_d[CW-1] != rdPtr_d[CW-1]) &&
                  (wrPtr_d[AW-1:0] == rdPtr_d[AW-1:0]);
    empty_d     = (wrPtr_d == rdPtr_d);
    progFull_d  = (count_d >= CW'(PROG_FULL_THRESH));
    progEmpty_d = (count_d <= CW'(PROG_EMPTY_THRESH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      progFull_q  <= 1'b0;
      progEmpty_q <= 1'b1;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      progFull_q  <= progFull_d;
      progEmpty_q <= progEmpty_d;
    end
  end

  // Storage is deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && wrAccept) begin
      mem_q[wrPtr_q[AW-1:0]] <= din;
    end
  end

  generate
    if (READ_MODE != 0) begin : gFwft
      assign dout       = empty_q ? '0 : mem_q[rdPtr_q[AW-1:0]];
      assign data_valid = !empty_q;
    end else begin : gStandard
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  dataValid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q      <= '0;
          dataValid_q <= 1'b0;
        end else begin
          dataValid_q <= rdAccept;
          if (rdAccept) begin
            dout_q <= mem_q[rdPtr_q[AW-1:0]];
          end
        end
      end

      assign dout       = dout_q;
      assign data_valid = dataValid_q;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= wr_en && full_q;
      underflow_q <= rd_en && empty_q;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  assign full       = full_q;
  assign empty      = empty_q;
  assign prog_full  = progFull_q;
  assign prog_empty = progEmpty_q;
  assign data_count = count_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: drives one FWFT and one standard-mode sync_fifo_ctrl with identical traffic and scores both against a queue model.
module tb_sync_fifo_ctrl;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int PFT   = 10;
  localparam int PET   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] din = '0;
  logic          wrEn = 1'b0;
  logic          rdEn = 1'b0;

  logic          fFull, fProgFull, fEmpty, fProgEmpty, fValid;
  logic [DW-1:0] fDout;
  logic [CW-1:0] fCount;
  logic          sFull, sProgFull, sEmpty, sProgEmpty, sValid;
  logic [DW-1:0] sDout;
  logic [CW-1:0] sCount;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic          fOvf, fUnf, sOvf, sUnf;
`endif

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .READ_MODE(1),
    .PROG_FULL_THRESH(PFT), .PROG_EMPTY_THRESH(PET)
  ) uFwft (
    .clk(clk), .rst(rst), .din(din), .wr_en(wrEn), .full(fFull),
    .prog_full(fProgFull), .rd_en(rdEn), .dout(fDout), .empty(fEmpty),
    .prog_empty(fProgEmpty), .data_valid(fValid), .data_count(fCount)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(fOvf), .underflow(fUnf)
`endif
  );

  sync_fifo_ctrl #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .READ_MODE(0),
    .PROG_FULL_THRESH(PFT), .PROG_EMPTY_THRESH(PET)
  ) uStd (
    .clk(clk), .rst(rst), .din(din), .wr_en(wrEn), .full(sFull),
    .prog_full(sProgFull), .rd_en(rdEn), .dout(sDout), .empty(sEmpty),
    .prog_empty(sProgEmpty), .data_valid(sValid), .data_count(sCount)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .overflow(sOvf), .underflow(sUnf)
`endif
  );

  typedef struct {
    int            count;
    bit            empty;
    bit            full;
    bit            pf;
    bit            pe;
    logic [DW-1:0] fwftDout;
    bit            stdValid;
    logic [DW-1:0] stdDout;
    bit            ovf;
    bit            unf;
  } expT;

  expT           expQ[$];
  logic [DW-1:0] model[$];
  logic [DW-1:0] lastStd = '0;
  int            compared = 0;
  int            mismatched = 0;
  int            cycleNo = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycleNo, act, exp);
    end
  endtask

  // One bus cycle of stimulus; the model advances in lockstep and queues what the DUTs must show after the edge.
  task automatic applyStimulus(input bit r, input bit w, input bit rd, input logic [DW-1:0] d);
    expT e;
    bit  wAcc, rAcc;
    @(negedge clk);
    rst  = r;
    wrEn = w;
    rdEn = rd;
    din  = d;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    e.stdValid = 1'b0;
    if (r) begin
      model.delete();
      lastStd = '0;
    end else begin
      e.ovf = w && (model.size() == DEPTH);
      e.unf = rd && (model.size() == 0);
      wAcc  = w && (model.size() < DEPTH);
      rAcc  = rd && (model.size() > 0);
      e.stdValid = rAcc;
      if (rAcc) lastStd = model.pop_front();
      if (wAcc) model.push_back(d);
    end
    e.count    = model.size();
    e.empty    = (model.size() == 0);
    e.full     = (model.size() == DEPTH);
    e.pf       = (model.size() >= PFT);
    e.pe       = (model.size() <= PET);
    e.fwftDout = (model.size() == 0) ? '0 : model[0];
    e.stdDout  = lastStd;
    expQ.push_back(e);
  endtask

  // Monitor: pops one expected record per clock and compares both instances.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      cycleNo++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("fwft_count", 32'(fCount), 32'(e.count));
        checkOutput("fwft_empty", 32'(fEmpty), 32'(e.empty));
        checkOutput("fwft_full", 32'(fFull), 32'(e.full));
        checkOutput("fwft_prog_full", 32'(fProgFull), 32'(e.pf));
        checkOutput("fwft_prog_empty", 32'(fProgEmpty), 32'(e.pe));
        checkOutput("fwft_valid", 32'(fValid), 32'(!e.empty));
        checkOutput("fwft_dout", 32'(fDout), 32'(e.fwftDout));
        checkOutput("std_count", 32'(sCount), 32'(e.count));
        checkOutput("std_empty", 32'(sEmpty), 32'(e.empty));
        checkOutput("std_full", 32'(sFull), 32'(e.full));
        checkOutput("std_prog_full", 32'(sProgFull), 32'(e.pf));
        checkOutput("std_prog_empty", 32'(sProgEmpty), 32'(e.pe));
        checkOutput("std_valid", 32'(sValid), 32'(e.stdValid));
        checkOutput("std_dout", 32'(sDout), 32'(e.stdDout));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checkOutput("fwft_overflow", 32'(fOvf), 32'(e.ovf));
        checkOutput("fwft_underflow", 32'(fUnf), 32'(e.unf));
        checkOutput("std_overflow", 32'(sOvf), 32'(e.ovf));
        checkOutput("std_underflow", 32'(sUnf), 32'(e.unf));
`endif
      end
    end
  end

  initial begin
    applyStimulus(1, 0, 0, '0);
    applyStimulus(1, 0, 0, '0);

    // Fill to full, then push once more while full.
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0, DW'(i));
    applyStimulus(0, 1, 0, 16'hDEAD);

    // Full with simultaneous write and read: write dropped, one word read.
    applyStimulus(0, 1, 1, 16'hBEEF);
    applyStimulus(0, 0, 0, '0);

    // Drain past empty so trailing reads hit an empty FIFO.
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(0, 0, 1, '0);

    // Empty with simultaneous write and read: only the write lands.
    applyStimulus(0, 1, 1, 16'h1234);
    applyStimulus(0, 0, 1, '0);

    // Single word into empty FIFO, then pop it.
    applyStimulus(0, 1, 0, 16'hA5A5);
    applyStimulus(0, 0, 0, '0);
    applyStimulus(0, 0, 1, '0);
    applyStimulus(0, 0, 0, '0);

    // Three queued words read back on consecutive cycles.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, DW'(16'h0C00 + i));
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, '0);
    applyStimulus(0, 0, 0, '0);

    // Random traffic: balanced, write-heavy, then read-heavy.
    for (int i = 0; i < 300; i++)
      applyStimulus(0, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, DW'($urandom));
    for (int i = 0; i < 80; i++)
      applyStimulus(0, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20, DW'($urandom));
    for (int i = 0; i < 80; i++)
      applyStimulus(0, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 85, DW'($urandom));

    // Interleaved writes/reads across two pointer wraps, then reset with a write pending.
    for (int i = 0; i < 40; i++) applyStimulus(0, 1, (i > 0), DW'(16'h0100 + i));
    applyStimulus(1, 1, 0, 16'hFFFF);
    applyStimulus(0, 0, 0, '0);
    applyStimulus(0, 0, 1, '0);

    repeat (3) @(posedge clk);
    #2;
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
